imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate generator for the decode stage.
- Extracts the format-specific RISC-V immediate and sign-extends it to XLEN.
- Classifies the instruction format and flags illegal encodings.
- Carries a sideband tag (e.g. PC) alongside each result.
- Uses a valid/ready handshake and a 2-entry skid buffer so in_ready is a registered signal; supports pipeline flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried alongside each instruction.
- RV64_OPS, 0, when 1 (requires XLEN=64), OP-IMM-32 (opcode 00110) is decoded as I-type and OP-32 (01110) as legal with no immediate; when 0 both are illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush; discards all held entries.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  block can accept an instruction; registered.
- in_instr  input  32  raw instruction word.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_imm  output  XLEN  sign-extended immediate.
- out_fmt  output  3  format: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J.
- out_illegal  output  1  unrecognised opcode or instr[1:0] != 2'b11.
- out_tag  output  TAG_W  tag of the presented result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=1, skid buffer empty.
  - out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_* fields are stable while out_valid && !out_ready.
- Latency: 1 cycle from input transfer to out_valid when the output register is empty or draining.
- Decode: opcode = instr[6:2]. Sign bit s = instr[31], replicated to XLEN.
  - I: 00000, 00011, 00100, 11001, 11100. imm = {s.., instr[30:20]}, fmt=1.
  - S: 01000. imm = {s.., instr[30:25], instr[11:7]}, fmt=2.
  - B: 11000. imm = {s.., instr[7], instr[30:25], instr[11:8], 0}, fmt=3.
  - U: 01101, 00101. imm = {s.. (bits XLEN-1:32, only when XLEN=64), instr[31:12], 12'b0}, fmt=4.
  - J: 11011. imm = {s.., instr[19:12], instr[20], instr[30:21], 0}, fmt=5.
  - R: 01100. imm=0, fmt=0, legal.
  - Any other opcode, or instr[1:0] != 2'b11: imm=0, fmt=0, out_illegal=1.
- Storage: output register plus one skid register.
  - State EMPTY: out_valid=0. Input transfer -> FULL1.
  - State FULL1: out_valid=1.
    - Input with no output transfer -> input goes to skid -> FULL2.
    - Output transfer with no input -> EMPTY.
    - Both in the same cycle -> stay FULL1, output register reloaded with the new input.
  - State FULL2: in_ready=0. Output transfer -> skid entry moves to the output register -> FULL1.
- in_ready is registered and equals (state != FULL2) for the next cycle.
- Ordering is strictly FIFO; there are no drops or duplicates.
- Flush:
  - Next state is EMPTY and in_ready=1.
  - An input presented in the flush cycle is dropped; so is any output transfer attempt in that cycle.
  - Flush takes priority over every simultaneous event.
- Reset mid-operation: immediate return to reset values; all held entries are lost.
- The block itself does not implement RV64-only opcodes when RV64_OPS=0; they report illegal.

Test Plan:
- XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- Back-to-back 0x123450B7 (lui), 0x0080006F (jal +8), 0xFE000EE3 (beq -4), 0xFE112C23 (sw -8) -> results in order:
  - 0x12345000 fmt4
  - 0x00000008 fmt5
  - 0xFFFFFFFC fmt3
  - 0xFFFFFFF8 fmt2
- XLEN=64, in_instr=0x800000B7 -> out_imm=0xFFFFFFFF80000000, fmt=4. Same with RV64_OPS=0 and opcode 00110 -> out_illegal=1, imm=0.
- Backpressure: out_ready=0 while feeding 3 instructions -> in_ready drops after the second is accepted, the third is held upstream. Raise out_ready -> all three emerge in order with matching tags.
- flush asserted in FULL2 with in_valid=1 -> next cycle out_valid=0, in_ready=1; neither held entry nor the flush-cycle input ever appears.
- rst_n pulsed low asynchronously (no clock edge) in FULL1 -> out_valid and out_imm go to 0 immediately; first post-reset input is decoded normally.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RISC-V immediate generator with 2-entry skid buffer
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 32,
    parameter int RV64_OPS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FULL1 = 2'd1;
    localparam logic [1:0] S_FULL2 = 2'd2;

    localparam logic [2:0] F_NONE = 3'd0;
    localparam logic [2:0] F_I    = 3'd1;
    localparam logic [2:0] F_S    = 3'd2;
    localparam logic [2:0] F_B    = 3'd3;
    localparam logic [2:0] F_U    = 3'd4;
    localparam logic [2:0] F_J    = 3'd5;

    logic [1:0]       state, state_nxt;
    logic             in_xfer, out_xfer;
    logic             load_out_dec, load_out_skid, load_skid;

    logic             s;
    logic [XLEN-1:0]  i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_ill;

    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_ill;
    logic [TAG_W-1:0] skid_tag;

    assign in_xfer   = in_valid && in_ready;
    assign out_valid = (state != S_EMPTY);
    assign out_xfer  = out_valid && out_ready;

    // instr[31] is the sign bit in every format, so U-type needs no special XLEN case
    assign s     = in_instr[31];
    assign i_imm = {{(XLEN-11){s}}, in_instr[30:20]};
    assign s_imm = {{(XLEN-11){s}}, in_instr[30:25], in_instr[11:7]};
    assign b_imm = {{(XLEN-12){s}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign u_imm = {{(XLEN-31){s}}, in_instr[30:12], 12'b0};
    assign j_imm = {{(XLEN-20){s}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        dec_imm = '0;
        dec_fmt = F_NONE;
        dec_ill = 1'b0;
        case (in_instr[6:2])
            5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100: begin
                dec_imm = i_imm;
                dec_fmt = F_I;
            end
            5'b01000: begin
                dec_imm = s_imm;
                dec_fmt = F_S;
            end
            5'b11000: begin
                dec_imm = b_imm;
                dec_fmt = F_B;
            end
            5'b01101, 5'b00101: begin
                dec_imm = u_imm;
                dec_fmt = F_U;
            end
            5'b11011: begin
                dec_imm = j_imm;
                dec_fmt = F_J;
            end
            5'b01100: ;
            5'b00110: begin
                if (RV64_OPS != 0) begin
                    dec_imm = i_imm;
                    dec_fmt = F_I;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            5'b01110: dec_ill = (RV64_OPS == 0);
            default:  dec_ill = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) begin
            dec_imm = '0;
            dec_fmt = F_NONE;
            dec_ill = 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        load_out_dec  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            S_EMPTY: begin
                if (in_xfer) begin
                    state_nxt    = S_FULL1;
                    load_out_dec = 1'b1;
                end
            end
            S_FULL1: begin
                if (in_xfer && !out_xfer) begin
                    state_nxt = S_FULL2;
                    load_skid = 1'b1;
                end else if (!in_xfer && out_xfer) begin
                    state_nxt = S_EMPTY;
                end else if (in_xfer && out_xfer) begin
                    load_out_dec = 1'b1;
                end
            end
            S_FULL2: begin
                if (out_xfer) begin
                    state_nxt     = S_FULL1;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_EMPTY;
            in_ready    <= 1'b1;
            out_imm     <= '0;
            out_fmt     <= F_NONE;
            out_illegal <= 1'b0;
            out_tag     <= '0;
            skid_imm    <= '0;
            skid_fmt    <= F_NONE;
            skid_ill    <= 1'b0;
            skid_tag    <= '0;
        end else if (flush) begin
            state    <= S_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != S_FULL2);
            if (load_out_dec) begin
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_ill;
                out_tag     <= in_tag;
            end else if (load_out_skid) begin
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_ill;
                out_tag     <= skid_tag;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_fmt <= dec_fmt;
                skid_ill <= dec_ill;
                skid_tag <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed vector bench for imm_gen_pipe (32-bit, 64-bit, 64-bit with RV64 ops)
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;

    logic        a_in_ready, a_out_valid, a_ill;
    logic [31:0] a_imm, a_tag;
    logic [2:0]  a_fmt;
    logic        b_in_ready, b_out_valid, b_ill;
    logic [63:0] b_imm;
    logic [31:0] b_tag;
    logic [2:0]  b_fmt;
    logic        c_in_ready, c_out_valid, c_ill;
    logic [63:0] c_imm;
    logic [31:0] c_tag;
    logic [2:0]  c_fmt;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .RV64_OPS(0)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_imm),
        .out_fmt(a_fmt), .out_illegal(a_ill), .out_tag(a_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .RV64_OPS(0)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_imm),
        .out_fmt(b_fmt), .out_illegal(b_ill), .out_tag(b_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .RV64_OPS(1)) u64o (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_imm(c_imm),
        .out_fmt(c_fmt), .out_illegal(c_ill), .out_tag(c_tag)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] imm_o;
        logic [2:0]  fmt_o;
        logic        ill_o;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [31:0] instr, input logic [63:0] imm, input logic [2:0] fmt,
                                input logic ill, input logic [63:0] imm_o, input logic [2:0] fmt_o,
                                input logic ill_o);
        vec_t v;
        v.instr = instr; v.imm = imm; v.fmt = fmt; v.ill = ill;
        v.imm_o = imm_o; v.fmt_o = fmt_o; v.ill_o = ill_o;
        return v;
    endfunction

    task automatic send(input logic [31:0] instr, input logic [31:0] tag);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
    endtask

    initial begin
        vecs[0]  = mk(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0);
        vecs[1]  = mk(32'h123450B7, 64'h0000000012345000, 3'd4, 0, 64'h0000000012345000, 3'd4, 0);
        vecs[2]  = mk(32'h0080006F, 64'h0000000000000008, 3'd5, 0, 64'h0000000000000008, 3'd5, 0);
        vecs[3]  = mk(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 0);
        vecs[4]  = mk(32'hFE112C23, 64'hFFFFFFFFFFFFFFF8, 3'd2, 0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 0);
        vecs[5]  = mk(32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 0, 64'hFFFFFFFF80000000, 3'd4, 0);
        vecs[6]  = mk(32'h00A00513, 64'h000000000000000A, 3'd1, 0, 64'h000000000000000A, 3'd1, 0);
        vecs[7]  = mk(32'h002081B3, 64'h0,                3'd0, 0, 64'h0,                3'd0, 0);
        vecs[8]  = mk(32'hFFF0009B, 64'h0,                3'd0, 1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0);
        vecs[9]  = mk(32'h002081BB, 64'h0,                3'd0, 1, 64'h0,                3'd0, 0);
        vecs[10] = mk(32'hFFF00090, 64'h0,                3'd0, 1, 64'h0,                3'd0, 1);
        vecs[11] = mk(32'h0000007F, 64'h0,                3'd0, 1, 64'h0,                3'd0, 1);
        vecs[12] = mk(32'hFFFFF097, 64'hFFFFFFFFFFFFF000, 3'd4, 0, 64'hFFFFFFFFFFFFF000, 3'd4, 0);
        vecs[13] = mk(32'h7FF02083, 64'h00000000000007FF, 3'd1, 0, 64'h00000000000007FF, 3'd1, 0);
        vecs[14] = mk(32'h800080E7, 64'hFFFFFFFFFFFFF800, 3'd1, 0, 64'hFFFFFFFFFFFFF800, 3'd1, 0);
        vecs[15] = mk(32'h7FFFF0EF, 64'h00000000000FFFFE, 3'd5, 0, 64'h00000000000FFFFE, 3'd5, 0);
        vecs[16] = mk(32'hC0002573, 64'hFFFFFFFFFFFFFC00, 3'd1, 0, 64'hFFFFFFFFFFFFFC00, 3'd1, 0);

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_in_ready",  64'(a_in_ready),  64'd1);
        check("rst_imm32",     64'(a_imm),       64'd0);
        check("rst_imm64",     b_imm,            64'd0);
        check("rst_fmt",       64'(a_fmt),       64'd0);
        check("rst_illegal",   64'(a_ill),       64'd0);
        check("rst_tag",       64'(a_tag),       64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Streaming table: result of vector i-1 is visible while vector i is presented
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("v%0d_valid", i-1),  64'(a_out_valid), 64'd1);
                check($sformatf("v%0d_imm32", i-1),  64'(a_imm),  64'(vecs[i-1].imm[31:0]));
                check($sformatf("v%0d_fmt32", i-1),  64'(a_fmt),  64'(vecs[i-1].fmt));
                check($sformatf("v%0d_ill32", i-1),  64'(a_ill),  64'(vecs[i-1].ill));
                check($sformatf("v%0d_tag", i-1),    64'(a_tag),  64'(32'hA0000000 + 32'(i-1)));
                check($sformatf("v%0d_imm64", i-1),  b_imm,       vecs[i-1].imm);
                check($sformatf("v%0d_fmt64", i-1),  64'(b_fmt),  64'(vecs[i-1].fmt));
                check($sformatf("v%0d_ill64", i-1),  64'(b_ill),  64'(vecs[i-1].ill));
                check($sformatf("v%0d_imm64o", i-1), c_imm,       vecs[i-1].imm_o);
                check($sformatf("v%0d_fmt64o", i-1), 64'(c_fmt),  64'(vecs[i-1].fmt_o));
                check($sformatf("v%0d_ill64o", i-1), 64'(c_ill),  64'(vecs[i-1].ill_o));
                check($sformatf("v%0d_in_ready", i-1), 64'(a_in_ready), 64'd1);
            end
            if (i < NV) send(vecs[i].instr, 32'hA0000000 + 32'(i));
            else in_valid = 1'b0;
        end
        @(negedge clk);
        check("table_drained", 64'(a_out_valid), 64'd0);

        // Backpressure: third instruction is held upstream until the skid drains
        out_ready = 1'b0;
        send(32'h123450B7, 32'h1);
        @(negedge clk);
        check("bp_valid1", 64'(a_out_valid), 64'd1);
        check("bp_ready1", 64'(a_in_ready), 64'd1);
        send(32'h0080006F, 32'h2);
        @(negedge clk);
        check("bp_ready_low", 64'(a_in_ready), 64'd0);
        check("bp_tag_hold1", 64'(a_tag), 64'h1);
        send(32'hFE000EE3, 32'h3);
        @(negedge clk);
        check("bp_ready_low2", 64'(a_in_ready), 64'd0);
        check("bp_tag_hold2", 64'(a_tag), 64'h1);
        check("bp_imm_hold", 64'(a_imm), 64'h12345000);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_tag2", 64'(a_tag), 64'h2);
        check("bp_imm2", 64'(a_imm), 64'h8);
        check("bp_fmt2", 64'(a_fmt), 64'd5);
        check("bp_ready_back", 64'(a_in_ready), 64'd1);
        @(negedge clk);
        check("bp_tag3", 64'(a_tag), 64'h3);
        check("bp_imm3", b_imm, 64'hFFFFFFFFFFFFFFFC);
        check("bp_fmt3", 64'(a_fmt), 64'd3);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_empty", 64'(a_out_valid), 64'd0);

        // Flush while FULL2 with a live input and a live output_ready
        out_ready = 1'b0;
        send(32'hFFF00093, 32'h11);
        @(negedge clk);
        send(32'h123450B7, 32'h12);
        @(negedge clk);
        check("fl_full2", 64'(a_in_ready), 64'd0);
        flush = 1'b1;
        out_ready = 1'b1;
        send(32'h00A00513, 32'h13);
        @(negedge clk);
        check("fl_valid", 64'(a_out_valid), 64'd0);
        check("fl_ready", 64'(a_in_ready), 64'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("fl_stays_empty", 64'(a_out_valid), 64'd0);
        send(32'h7FFFF0EF, 32'h14);
        @(negedge clk);
        check("fl_post_valid", 64'(a_out_valid), 64'd1);
        check("fl_post_tag", 64'(a_tag), 64'h14);
        check("fl_post_imm", 64'(a_imm), 64'h000FFFFE);
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_no_ghost", 64'(a_out_valid), 64'd0);

        // Asynchronous reset between clock edges while FULL1
        out_ready = 1'b0;
        send(32'hFFF00093, 32'h21);
        @(negedge clk);
        check("ar_pre_valid", 64'(a_out_valid), 64'd1);
        check("ar_pre_imm", 64'(a_imm), 64'hFFFFFFFF);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(a_out_valid), 64'd0);
        check("ar_imm32", 64'(a_imm), 64'd0);
        check("ar_imm64", b_imm, 64'd0);
        check("ar_tag", 64'(a_tag), 64'd0);
        check("ar_ready", 64'(a_in_ready), 64'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        send(32'hFE112C23, 32'h22);
        @(negedge clk);
        check("ar_post_valid", 64'(a_out_valid), 64'd1);
        check("ar_post_imm", b_imm, 64'hFFFFFFFFFFFFFFF8);
        check("ar_post_fmt", 64'(a_fmt), 64'd2);
        check("ar_post_tag", 64'(a_tag), 64'h22);
        in_valid = 1'b0;
        @(negedge clk);
        check("ar_post_empty", 64'(a_out_valid), 64'd0);
        check("ar_u64_valid", 64'(b_out_valid | c_out_valid), 64'd0);
        check("ar_u64_ready", 64'(b_in_ready & c_in_ready), 64'd1);
        check("ar_u64_tags", 64'(b_tag ^ c_tag), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
